m31_poseidon2_arbiter: RTL
==========================

Name: m31_poseidon2_arbiter

Overview:
- Shares one m31_poseidon2_iterative core among N_REQ independent requesters. The core is non-pipelined and its valid_o pulse cannot be back-pressured.
- Selects requesters round-robin, issues exactly one permutation at a time, and tracks the owner.
- Captures the core's result pulse into a holding register and returns it tagged with the owner id.
- Sits between hash clients (Merkle/sponge engines) and the single permutation core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, state width in M31 elements; must match the core.
- ID_W, $clog2(N_REQ), owner id width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- req_state_i  in  N_REQ*WIDTH*31  per-requester input state (m31_t [N_REQ-1:0][WIDTH-1:0]).
- core_state_o  out  WIDTH*31  state to core state_i.
- core_valid_o  out  1  to core valid_i.
- core_ready_i  in  1  from core ready_o.
- core_state_i  in  WIDTH*31  from core state_o.
- core_valid_i  in  1  from core valid_o (single-cycle pulse).
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result accept.
- rsp_id_o  out  ID_W  owner of the result.
- rsp_state_o  out  WIDTH*31  result state.
- rsp_err_o  out  1  result is a timeout (0 when the feature is absent).
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst_n=0 at posedge) clears all state:
  - FSM goes to IDLE and rr_ptr=0.
  - All outputs are 0: req_ready_o, core_valid_o, rsp_valid_o, rsp_id_o, rsp_state_o, rsp_err_o, busy_o, core_state_o.
- Reset mid-operation abandons the job; the core is reset by the same rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is high, the grant k is the first valid index searching k = rr_ptr, rr_ptr+1, … mod N_REQ.
  - req_ready_o[k]=1 combinationally in that same cycle; the request is accepted on that edge.
  - req_state_i[k] is latched into job_reg and k into owner; next state is ISSUE.
  - No request valid: stay in IDLE.
- ISSUE:
  - core_valid_o=1 with core_state_o=job_reg.
  - Transfer occurs in a cycle where core_ready_i=1; next state is WAIT.
  - While core_ready_i=0, hold ISSUE with core_valid_o asserted.
- WAIT:
  - core_valid_o=0.
  - On core_valid_i=1, capture core_state_i into rsp_state_o; rsp_id_o=owner; rsp_err_o=0; next state is RESP.
- RESP:
  - rsp_valid_o=1; the response holds stable until rsp_ready_i=1.
  - On the handshake: rr_ptr=(owner+1) mod N_REQ, rsp_valid_o drops next cycle, next state is IDLE.
- New requests are never accepted outside IDLE. req_ready_o is 0 in ISSUE, WAIT and RESP.
- core_valid_i outside WAIT is ignored and does not alter the response.
- Requester protocol: req_valid_i/req_state_i must stay stable until accepted. The arbiter does not require this; it samples only on the accept cycle.
- Latency:
  - Request acceptance at edge t; core_valid_o is high in cycle t+1.
  - rsp_valid_o rises the cycle after the core's valid_o pulse.
  - Minimum request-to-request spacing is the core latency plus 3 cycles.
- Arithmetic: no field arithmetic is performed; data passes through unchanged.

Optional Feature:
- Macro M31_P2_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before core_valid_i, go to RESP with rsp_err_o=1, rsp_state_o=0, rsp_id_o=owner.
  - If core_valid_i and the timeout occur in the same cycle, the result wins with err=0.
- When undefined: there is no counter, WAIT waits indefinitely, and rsp_err_o is tied to 0.

Decomposition:
- m31_pkg already provides m31_t and P_M31.
- Add to m31_pkg: localparam P2_WIDTH=16 and typedef p2_state_t (m31_t [P2_WIDTH-1:0]).
- Add to m31_pkg: typedef enum of the FSM states (P2A_IDLE, P2A_ISSUE, P2A_WAIT, P2A_RESP).
- One sub-module, m31_rr_arbiter: combinational round-robin selector with inputs req vector and ptr, and outputs one-hot grant and index.

Test Plan:
- Single request from requester 2 with state 1..16 (real core) -> rsp_id=2, rsp_state[0]=0x34ecac18, [15]=0x60f6e959, rsp_err=0.
- Requesters 0 and 2 valid together after reset (rr_ptr=0) -> grant order 0 then 2. Requester 2 carries the 0x35564d4d… vector and returns [0]=0x43074f9a, [15]=0x1341ad2d.
- All four requesters held valid continuously -> grant order 0,1,2,3,0; no requester is granted twice before the others.
- Hold rsp_ready_i=0 for 50 cycles -> rsp_valid/id/state stable, req_ready_o all 0, then IDLE one cycle after the handshake.
- Stub core with core_ready_i low for 10 cycles, then a spurious core_valid_i during RESP -> core_valid_o held 10 cycles; the stray pulse is ignored.
- rst_n low during WAIT, followed by a new request -> all outputs 0, rr_ptr=0, and the new job completes correctly. With M31_P2_ARB_TIMEOUT_EN and a silent stub core -> rsp_err=1 after exactly TIMEOUT_CYCLES in WAIT.

Source files
------------

// File: rtl/m31_pkg.sv
// Shared M31 field types plus the Poseidon2 arbiter state/FSM types.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7fff_ffff;

  // Poseidon2 state width in M31 elements.
  localparam int P2_WIDTH = 16;

  typedef m31_t [P2_WIDTH-1:0] p2_state_t;

  // Poseidon2 arbiter FSM states.
  typedef enum logic [1:0] {
    P2A_IDLE,
    P2A_ISSUE,
    P2A_WAIT,
    P2A_RESP
  } p2a_state_e;

endpackage

// File: rtl/m31_rr_arbiter.sv
// Combinational round-robin selector: the first asserted request at or after
// ptr (wrapping modulo N_REQ) wins. Outputs a one-hot grant and its index.
module m31_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  // cand[i] is the requester index examined at priority position i.
  logic [N_REQ-1:0][ID_W-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(ptr) + gi) % N_REQ);
    end
  endgenerate

  // Scan from lowest to highest priority so the nearest valid request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant          = '0;
        grant[cand[i]] = 1'b1;
        idx            = cand[i];
      end
    end
  end

endmodule

// File: rtl/m31_poseidon2_arbiter.sv
// Shares one non-pipelined Poseidon2 core among N_REQ requesters: round-robin
// grant, one permutation in flight, result held and tagged with its owner.
// Optional watchdog on the core result: define M31_P2_ARB_TIMEOUT_EN.
module m31_poseidon2_arbiter
  import m31_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 16,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  m31_t [N_REQ-1:0][WIDTH-1:0]  req_state_i,
  output m31_t [WIDTH-1:0]             core_state_o,
  output logic                         core_valid_o,
  input  logic                         core_ready_i,
  input  m31_t [WIDTH-1:0]             core_state_i,
  input  logic                         core_valid_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_W-1:0]              rsp_id_o,
  output m31_t [WIDTH-1:0]             rsp_state_o,
  output logic                         rsp_err_o,
  output logic                         busy_o
);

  p2a_state_e       state_reg, state_next;
  logic [ID_W-1:0]  rr_ptr_reg, owner_reg, grant_idx;
  logic [N_REQ-1:0] grant;
  m31_t [WIDTH-1:0] job_reg, rsp_state_reg;
  logic             rsp_err_reg;
  logic             any_req;
  logic             timeout_hit;

  assign any_req = |req_valid_i;

  m31_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req   (req_valid_i),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

`ifdef M31_P2_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_reg;

  // Count WAIT cycles; cleared while issuing so each job starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == P2A_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == P2A_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 32'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle result still wins.
  assign timeout_hit = (state_reg == P2A_WAIT) &&
                       (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog WAIT only ends on a core result.
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= P2A_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    req_ready_o  = '0;
    core_valid_o = 1'b0;
    core_state_o = '0;
    rsp_valid_o  = 1'b0;
    busy_o       = (state_reg != P2A_IDLE);
    unique case (state_reg)
      P2A_IDLE: begin
        // Gated by rst_n so nothing is acknowledged while reset is applied.
        if (rst_n) req_ready_o = grant;
        if (any_req) state_next = P2A_ISSUE;
      end
      P2A_ISSUE: begin
        core_valid_o = 1'b1;
        core_state_o = job_reg;
        if (core_ready_i) state_next = P2A_WAIT;
      end
      P2A_WAIT: begin
        if (core_valid_i || timeout_hit) state_next = P2A_RESP;
      end
      P2A_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = P2A_IDLE;
      end
      default: state_next = P2A_IDLE;
    endcase
  end

  // Job capture, result capture and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      job_reg       <= '0;
      rsp_state_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      unique case (state_reg)
        P2A_IDLE: begin
          if (any_req) begin
            job_reg   <= req_state_i[grant_idx];
            owner_reg <= grant_idx;
          end
        end
        P2A_WAIT: begin
          if (core_valid_i) begin
            rsp_state_reg <= core_state_i;
            rsp_err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_state_reg <= '0;
            rsp_err_reg   <= 1'b1;
          end
        end
        P2A_RESP: begin
          if (rsp_ready_i) begin
            rr_ptr_reg <= (owner_reg == ID_W'(N_REQ - 1)) ? '0
                                                          : owner_reg + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id_o    = owner_reg;
  assign rsp_state_o = rsp_state_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule
